// File: rtl/cfg_chain_pkg.sv
// cfg_chain_pkg: shared FSM state, slot layout and frame-size helpers for the config chain
package cfg_chain_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, FLAG, PAYLOAD, FINISH} state_t;
  localparam int FLAG_OFS = 0;
  localparam int PAYLOAD_OFS = 1;
  function automatic int frame_len(input int num_tiles, input int mem_cycles);
    return num_tiles + num_tiles * mem_cycles;
  endfunction
  function automatic int words_per_tile(input int mem_cycles, input int word_w);
    return (mem_cycles - PAYLOAD_OFS + word_w - 1) / word_w;
  endfunction
endpackage

// File: rtl/cfg_chain_tx_if.sv
// cfg_chain_tx_if: word stream feeding the chain transmitter
//   in_data  payload word, LSB first on the chain
//   in_valid source holds a word
//   in_ready transmitter accepts the word this cycle
interface cfg_chain_tx_if #(parameter int WORD_W = 8);
  logic [WORD_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master (output in_data, in_valid, input in_ready);
  modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: holding + shift register turning stream words into payload bits
//   clk, rst     clock, asynchronous active-low reset
//   load         frame accepted: arm word budget, drop any held word
//   busy         frame in progress (gates in_ready)
//   clr          flag cycle: next payload cycle starts a fresh word
//   shift        payload cycle of a loaded tile
//   n_words      words the whole frame will consume
//   s            word stream (slave side)
//   bit_o        payload bit for this cycle
//   miss         word boundary found the holding register empty
module cfg_word_serializer #(parameter int WORD_W = 8, parameter int RW = 4) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic busy,
  input  logic clr,
  input  logic shift,
  input  logic [RW-1:0] n_words,
  cfg_chain_tx_if.slave s,
  output logic bit_o,
  output logic miss
);
  localparam int BW = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] hold, sr;
  logic hold_full, word_ok, bnd, xfer;
  logic [BW-1:0] bc;
  logic [RW-1:0] rem;
  assign bnd = shift & (bc == '0);
  assign miss = bnd & ~hold_full;
  // a missed word still uses up one word of the budget
  assign s.in_ready = busy & ~hold_full & (rem > RW'(miss));
  assign xfer = s.in_valid & s.in_ready;
  assign bit_o = bnd ? hold_full & hold[0] : word_ok & sr[0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold <= '0;
      sr <= '0;
      hold_full <= 1'b0;
      word_ok <= 1'b0;
      bc <= '0;
      rem <= '0;
    end else begin
      rem <= load ? n_words : rem - RW'(xfer) - RW'(miss);
      hold_full <= load ? 1'b0 : xfer | (hold_full & ~bnd);
      if (xfer) hold <= s.in_data;
      bc <= clr ? '0 : shift ? (bc == BW'(WORD_W - 1) ? '0 : bc + 1'b1) : bc;
      sr <= bnd ? hold >> 1 : shift ? sr >> 1 : sr;
      if (bnd) word_ok <= hold_full;
    end
endmodule

// File: rtl/cfg_chain_tx.sv
// cfg_chain_tx: serializes preamble + per-tile flag/payload slots onto the config daisy chain
//   clk, rst   clock, asynchronous active-low reset
//   start      frame request, honoured in IDLE only
//   tile_mask  tiles to load, latched on accepted start
//   s          payload word stream (slave side)
//   data_out   registered serial chain bit
//   busy       frame in progress
//   done       one-cycle pulse after the last slot bit
//   underrun   sticky until next start: a payload word was missing
module cfg_chain_tx import cfg_chain_pkg::*; #(
  parameter int NUM_TILES = 9,
  parameter int MEM_CYCLES = 32768,
  parameter int WORD_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [NUM_TILES-1:0] tile_mask,
  cfg_chain_tx_if.slave s,
  output logic data_out,
  output logic busy,
  output logic done,
  output logic underrun
);
  localparam int WPT = words_per_tile(MEM_CYCLES, WORD_W);
  localparam int SW = $clog2(MEM_CYCLES + 1);
  localparam int TW = $clog2(NUM_TILES + 1);
  localparam int RW = $clog2(NUM_TILES * WPT + 1);
  state_t st;
  logic [SW-1:0] cnt;
  logic [TW-1:0] tile;
  logic [NUM_TILES-1:0] mask;
  logic [RW-1:0] n_words;
  logic load, cur, last_t, ser_bit, miss;
  assign load = (st == IDLE) & start;
  assign cur = |(mask & (NUM_TILES'(1) << tile));
  assign last_t = tile == TW'(NUM_TILES - 1);
  assign n_words = RW'($countones(tile_mask) * WPT);
  cfg_word_serializer #(.WORD_W(WORD_W), .RW(RW)) u_ser (
    .clk(clk),
    .rst(rst),
    .load(load),
    .busy(busy),
    .clr(st == FLAG),
    .shift((st == PAYLOAD) & cur),
    .n_words(n_words),
    .s(s),
    .bit_o(ser_bit),
    .miss(miss)
  );
  // the tile counter doubles as the preamble counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      tile <= '0;
      mask <= '0;
      data_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      data_out <= st == FLAG ? cur : (st == PAYLOAD) & cur & ser_bit;
      done <= st == FINISH;
      underrun <= load ? 1'b0 : underrun | miss;
      case (st)
        IDLE: if (start) begin
          st <= PREAMBLE;
          mask <= tile_mask;
          tile <= '0;
          busy <= 1'b1;
        end
        PREAMBLE: begin
          tile <= last_t ? '0 : tile + 1'b1;
          cnt <= SW'(FLAG_OFS);
          if (last_t) st <= FLAG;
        end
        FLAG: begin
          cnt <= cnt + 1'b1;
          st <= PAYLOAD;
        end
        PAYLOAD: if (cnt == SW'(MEM_CYCLES - 1)) begin
          cnt <= SW'(FLAG_OFS);
          tile <= tile + 1'b1;
          st <= last_t ? FINISH : FLAG;
        end else cnt <= cnt + 1'b1;
        FINISH: begin
          st <= IDLE;
          busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cfg_chain_tx.sv
// tb_cfg_chain_tx: directed frames on a 3-tile, 5-cycle-slot chain with 2- and 3-bit words
module tb_cfg_chain_tx;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [2:0] tile_mask = '0;
  logic d0, b0, dn0, u0, d1, b1, dn1, u1;
  int n_tests = 0, n_fail = 0;
  int idx0 = 0, idx1 = 0, nx0 = 0, nx1 = 0;
  logic xf0 = 1'b0, xf1 = 1'b0, gap = 1'b0;
  logic [1:0] w0 [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
  logic [2:0] w1 [6] = '{3'b101, 3'b110, 3'b011, 3'b001, 3'b000, 3'b111};
  cfg_chain_tx_if #(.WORD_W(2)) s0();
  cfg_chain_tx_if #(.WORD_W(3)) s1();
  cfg_chain_tx #(.NUM_TILES(3), .MEM_CYCLES(5), .WORD_W(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .tile_mask(tile_mask), .s(s0),
    .data_out(d0), .busy(b0), .done(dn0), .underrun(u0));
  cfg_chain_tx #(.NUM_TILES(3), .MEM_CYCLES(5), .WORD_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .tile_mask(tile_mask), .s(s1),
    .data_out(d1), .busy(b1), .done(dn1), .underrun(u1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  // word sources; with gap set, word 2 of dut0 is withheld and dropped once underrun shows
  task automatic src_step();
    if (xf0) begin idx0++; nx0++; end
    if (xf1) begin idx1++; nx1++; end
    if (gap && idx0 == 2 && u0) idx0 = 3;
    s0.in_valid = idx0 < 6 && !(gap && idx0 == 2);
    s0.in_data = idx0 < 6 ? w0[idx0] : '0;
    s1.in_valid = idx1 < 6;
    s1.in_data = idx1 < 6 ? w1[idx1] : '0;
    xf0 = s0.in_valid & s0.in_ready;
    xf1 = s1.in_valid & s1.in_ready;
  endtask
  task automatic cyc();
    @(negedge clk);
    src_step();
    @(posedge clk);
    #1;
  endtask
  task automatic arm(input logic [2:0] m, input logic g);
    idx0 = 0; idx1 = 0; nx0 = 0; nx1 = 0; xf0 = 1'b0; xf1 = 1'b0; gap = g;
    tile_mask = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
    tile_mask = '0;
  endtask
  task automatic run_frame(input string tag, input logic sel, input logic [2:0] m, input logic g,
                           input int stray, input logic [17:0] exp, input logic exp_u, input int exp_n);
    logic [17:0] f;
    int done_at, n_done, busy_last;
    f = '0; done_at = 0; n_done = 0; busy_last = 0;
    arm(m, g);
    for (int j = 1; j <= 22; j++) begin
      start = (j == stray);
      cyc();
      if (j <= 18) f = {f[16:0], sel ? d1 : d0};
      if (sel ? dn1 : dn0) begin
        n_done++;
        if (done_at == 0) done_at = j;
      end
      if (sel ? b1 : b0) busy_last = j;
    end
    start = 1'b0;
    chk({tag, ".frame"}, f, exp);
    chk({tag, ".done_at"}, done_at, 19);
    chk({tag, ".n_done"}, n_done, 1);
    chk({tag, ".busy_last"}, busy_last, 18);
    chk({tag, ".underrun"}, sel ? u1 : u0, exp_u);
    chk({tag, ".words"}, sel ? nx1 : nx0, exp_n);
  endtask
  initial begin
    int n_done;
    repeat (3) cyc();
    chk("rst.data_out", d0, 0);
    chk("rst.busy", b0, 0);
    chk("rst.done", dn0, 0);
    chk("rst.in_ready", s0.in_ready, 0);
    chk("rst.underrun", u0, 0);
    rst = 1'b1;
    cyc();
    run_frame("full", 1'b0, 3'b111, 1'b0, 0, {3'b000, 15'b11001_11100_11001}, 1'b0, 6);
    run_frame("mask010", 1'b0, 3'b010, 1'b0, 0, {3'b000, 15'b00000_11001_00000}, 1'b0, 2);
    run_frame("gap", 1'b0, 3'b111, 1'b1, 0, {3'b000, 15'b11001_10000_11001}, 1'b1, 5);
    run_frame("stray", 1'b0, 3'b111, 1'b0, 6, {3'b000, 15'b11001_11100_11001}, 1'b0, 6);
    run_frame("mask0", 1'b0, 3'b000, 1'b0, 0, 18'b0, 1'b0, 0);
    run_frame("w3", 1'b1, 3'b111, 1'b0, 0, {3'b000, 15'b11010_11101_10001}, 1'b0, 6);
    arm(3'b111, 1'b0);
    repeat (9) cyc();
    chk("mid.flag1", d0, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid.data_out", d0, 0);
    chk("mid.busy", b0, 0);
    n_done = 0;
    repeat (6) begin
      cyc();
      if (dn0) n_done++;
    end
    chk("mid.no_done", n_done, 0);
    rst = 1'b1;
    cyc();
    run_frame("after_rst", 1'b0, 3'b111, 1'b0, 0, {3'b000, 15'b11001_11100_11001}, 1'b0, 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cfg_chain_tx.md
Name: cfg_chain_tx

Overview:
- Host-side serializer that drives the tile configuration daisy chain. It produces the single-bit, clock-counted frame that the per-tile chain receivers decode.
- On a start pulse it emits a preamble, then one fixed-length slot per tile. Each slot carries a valid flag followed by that tile's memory image, taken from a word-wide stream interface.
- Sits between the configuration buffer/DMA and the data input of chain tile 0.

Parameters:
- NUM_TILES, 9, number of tiles on the chain; also the preamble length in cycles.
- MEM_CYCLES, 32768, slot length in cycles per tile: 1 flag cycle + (MEM_CYCLES-1) payload cycles.
- WORD_W, 8, width of the input data word.
- Derived PAYLOAD_BITS = MEM_CYCLES-1.
- Derived WORDS_PER_TILE = ceil(PAYLOAD_BITS/WORD_W).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle frame request; honoured only in IDLE.
- tile_mask  in  NUM_TILES  bit t=1 means tile t is loaded; sampled on accepted start.
- in_data  in  WORD_W  payload word, consumed LSB first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  transmitter takes in_data this cycle.
- data_out  out  1  serial chain output, registered.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last slot bit.
- underrun  out  1  sticky: a payload word was needed but not available.

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs and returns the FSM to IDLE, including mid-frame. Any partial frame is abandoned with no further bits and no done pulse.
- Reset values: data_out=0, busy=0, done=0, in_ready=0, underrun=0, holding register empty.
- FSM states: IDLE, PREAMBLE, FLAG, PAYLOAD, FINISH.
- IDLE:
  - data_out=0.
  - start=1 latches tile_mask, clears underrun, sets tile index=0, and moves to PREAMBLE. busy rises on the next cycle.
  - start outside IDLE is ignored.
- PREAMBLE: drive 0 for exactly NUM_TILES cycles, then go to FLAG.
- FLAG: one cycle, data_out=mask[tile].
  - Mask bit 1: go to PAYLOAD in load mode.
  - Mask bit 0: go to PAYLOAD in skip mode.
- PAYLOAD: exactly PAYLOAD_BITS cycles.
  - Load mode: shift out bits LSB first, WORD_W bits per word. The last word of a tile is truncated, and its unused upper bits are discarded.
  - Skip mode: data_out=0 and no words are consumed.
  - After the last payload cycle: if tile==NUM_TILES-1, go to FINISH; otherwise increment tile and go to FLAG.
- FINISH: one cycle with data_out=0 and done=1, then IDLE with busy=0.
- Timing: data_out is registered, so the bit for frame cycle k appears one clock after the state logic selects it.
  - Total frame length is NUM_TILES + NUM_TILES*MEM_CYCLES cycles, counted from the first preamble bit.
  - Tile t's flag appears at frame cycle NUM_TILES + t*MEM_CYCLES.
- Input buffering: one WORD_W shift register plus one holding register.
  - in_ready=1 while busy, the holding register is empty, and words remain to be fetched for a loaded tile. Prefetch is allowed during PREAMBLE and FLAG.
  - Transfer occurs when in_valid & in_ready.
  - The shift register reloads from the holding register at each word boundary.
- Underrun: the serial stream never stalls, because the chain counts clocks.
  - If the holding register is empty at a word boundary, emit 0 for that whole word and set underrun.
  - underrun stays set until the next accepted start.
  - The missing word is skipped, not delivered late. The fetch counter still advances.
- Simultaneous events:
  - in_valid together with a shift-register reload in the same cycle is legal. The holding register refills in that cycle.
  - start together with reset: reset wins.
- Counters: slot counter width $clog2(MEM_CYCLES+1); tile counter width $clog2(NUM_TILES+1). No wrap occurs within a legal frame.
- Edge cases:
  - NUM_TILES=1 is legal.
  - PAYLOAD_BITS < WORD_W is legal: one truncated word per tile.
  - tile_mask=0 produces a full-length all-zero frame and consumes no words.

Decomposition:
- Shared package cfg_chain_pkg:
  - FSM state enum.
  - Slot-layout constants: flag offset 0, payload offset 1.
  - Function for frame length and WORDS_PER_TILE. The receiver side uses the same functions.
- One natural sub-module: cfg_word_serializer, containing the holding register, shift register, bit counter and in_ready generation.

Test Plan (NUM_TILES=3, MEM_CYCLES=5, WORD_W=2 unless noted):
- mask=3'b111, words 01,10,11,00,01,10 always valid -> data_out after preamble 000: 1,1,0,0,1, 1,1,1,0,0, 1,1,0,0,1; done at cycle 19; underrun=0.
- mask=3'b010 -> slot0 all 0, slot1 flag 1 plus 4 payload bits from 2 words, slot2 all 0; exactly 2 words consumed.
- Same as first scenario with in_valid low for the 3rd word -> tile1's first 2 payload bits are 0, underrun=1 and stays set; later words are still taken in order.
- Reset asserted at frame cycle 8 -> data_out=0, busy=0 immediately (asynchronous); no done; next start gives a full correct frame.
- start pulsed during busy -> ignored; frame length unchanged.
- WORD_W=3, MEM_CYCLES=5 -> each tile consumes 2 words; the upper 2 bits of the 2nd word are discarded.
